frame_buffer_ctrl: RTL
======================

# frame_buffer_ctrl

Parametrised multi-buffer frame store between the ray marcher (writer) and the VGA display (reader), replacing the fixed double-buffered bram_manager. It holds NUM_BUFFERS pixel banks, rotates buffer ownership with a mailbox scheme, and applies swaps only at the reader's frame boundary so frames never tear. With NUM_BUFFERS=2 it stalls the writer until a swap; with NUM_BUFFERS≥3 it never stalls and drops superseded frames instead.

## Interface
- WIDTH, 4, bits per pixel
- DEPTH, `DISPLAY_WIDTH*`DISPLAY_HEIGHT, pixels per buffer
- ADDR_LEN, $clog2(DEPTH), pixel address width
- NUM_BUFFERS, 3, bank count, legal 2..4
- IDX_LEN, $clog2(NUM_BUFFERS), buffer index width (derived)

- clk_in  in  1  single clock for all logic
- rst_in  in  1  asynchronous, active-high reset
- write_enable_in  in  1  pixel write strobe
- write_addr_in  in  ADDR_LEN  pixel write address
- write_data_in  in  WIDTH  pixel write data
- write_frame_done_in  in  1  one-cycle pulse: writer finished current frame
- write_ready_out  out  1  a back buffer is owned by the writer
- read_addr_in  in  ADDR_LEN  display read address
- read_frame_start_in  in  1  one-cycle pulse at display frame boundary (vsync)
- read_data_out  out  WIDTH  pixel read data
- read_valid_out  out  1  read_data_out corresponds to an accepted address
- write_buf_out  out  IDX_LEN  bank currently owned by writer
- read_buf_out  out  IDX_LEN  bank currently displayed
- dropped_frames_out  out  16  saturating count of completed frames never displayed

## Operation
- State: read_idx, write_idx, pending_idx, pending_valid, write_ready; free set = banks not read, not write, not pending.
- Reset (async): read_idx=0, write_idx=1, pending_valid=0, write_ready_out=1, read_valid_out=0, read_data_out=0, dropped_frames_out=0; write_buf_out=1, read_buf_out=0.
- Writes: accepted only when write_enable_in && write_ready_out && write_addr_in<DEPTH; go to bank write_idx of that cycle. Others silently ignored.
- write_frame_done_in ignored when write_ready_out=0.
- Done, no frame start, pending_valid=0: pending_idx←write_idx, pending_valid←1; N≥3: write_idx←lowest free bank; N=2: write_ready_out←0.
- Done, no frame start, pending_valid=1 (only possible N≥3): pending_idx←write_idx, write_idx←old pending_idx, dropped_frames_out+1 (saturate at 16'hFFFF).
- Frame start, no done, pending_valid=1: read_idx←pending_idx, pending_valid←0; N=2: write_idx←old read_idx, write_ready_out←1. N≥3: old read_idx joins free set.
- Frame start, no done, pending_valid=0: no change (display repeats frame).
- Simultaneous done and frame start (write_ready_out=1): read_idx←write_idx, write_idx←old read_idx, pending_valid←0; if pending was valid it is freed and dropped_frames_out+1.
- Invariant: read_idx, write_idx, pending_idx (when valid) pairwise distinct; checked by assertion.

## Timing
- Read latency 2 cycles: address in cycle t, read_data_out/read_valid_out in t+2; read_valid_out is read_addr_in-in-range delayed 2 (reads continuous, no enable).
- Read bank selected in address cycle t; frame_start at t affects reads addressed from t+1.
- Write lands in BRAM one cycle after strobe; write in the same cycle as write_frame_done_in belongs to the finishing frame.
- Index/ready updates visible the cycle after the pulse; write_buf_out/read_buf_out registered.
- Reset mid-frame: ownership reverts to reset values; bank contents not cleared.

## Structure
- fb_pkg: buffer index helper function (lowest free bank from bitmask), max NUM_BUFFERS, dropped counter width; DISPLAY_WIDTH/HEIGHT remain in types.sv.
- Sub-module fb_bank: simple dual-port BRAM (WIDTH×DEPTH, 1 write port, 1 registered read port, 2-cycle latency), instantiated NUM_BUFFERS times via generate; read mux registered on bank index delayed to match latency.

## Test plan
- Reset then read addr 5 → read_data_out 0-initialised bank data at t+2, read_valid_out=1, read_buf_out=0, write_buf_out=1, write_ready_out=1.
- N=3: write 4'hA to addr 7, done, frame start, read addr 7 → 4'hA at t+2; read_buf_out=1, write_buf_out=2.
- N=3: three done pulses with no frame start → dropped_frames_out=2, write_ready_out stays 1, next frame start displays last completed frame.
- N=2: done → write_ready_out=0; writes of 4'h5 during stall absent from every bank; frame start → write_ready_out=1, write_buf_out=0.
- Simultaneous done and frame start with pending_valid=1 → read_buf_out=old write_buf_out, dropped_frames_out+1, pending cleared.
- write_addr_in=DEPTH and read_addr_in=DEPTH → no write, read_valid_out=0; assert rst_in mid-frame → all outputs at reset values same cycle.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and helpers for the multi-bank frame store.
// Display geometry macros come from types.sv; only ownership bookkeeping lives here.
package fb_pkg;

    localparam int MAX_BUFFERS = 4;
    localparam int BUF_IDX_W   = $clog2(MAX_BUFFERS);
    localparam int DROP_W      = 16;
    localparam int RD_LAT      = 2;

    typedef logic [BUF_IDX_W-1:0]   buf_idx_t;
    typedef logic [MAX_BUFFERS-1:0] buf_mask_t;

    // Encoded as {frame_start, accepted_done} so the event is a direct cast.
    typedef enum logic [1:0] {
        EV_NONE  = 2'b00,
        EV_DONE  = 2'b01,
        EV_START = 2'b10,
        EV_BOTH  = 2'b11
    } swap_ev_e;

    typedef struct packed {
        buf_idx_t read_idx;
        buf_idx_t write_idx;
        buf_idx_t pending_idx;
        logic     pending_valid;
        logic     write_ready;
    } own_t;

    localparam own_t OWN_RST = '{
        read_idx:      buf_idx_t'(0),
        write_idx:     buf_idx_t'(1),
        pending_idx:   buf_idx_t'(0),
        pending_valid: 1'b0,
        write_ready:   1'b1
    };

    function automatic buf_idx_t lowest_free(input buf_mask_t mask);
        buf_idx_t idx;
        idx = '0;
        for (int i = MAX_BUFFERS - 1; i >= 0; i--) begin
            if (mask[i]) idx = buf_idx_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/fb_bank.sv
// One pixel bank: simple dual-port RAM with a registered read port.
// The second latency stage is the registered read mux in the top level.
module fb_bank #(
    parameter int WIDTH    = 4,
    parameter int DEPTH    = 64,
    parameter int ADDR_LEN = $clog2(DEPTH)
) (
    input  logic                clk_in,
    input  logic                we,
    input  logic [ADDR_LEN-1:0] waddr,
    input  logic [WIDTH-1:0]    wdata,
    input  logic                re,
    input  logic [ADDR_LEN-1:0] raddr,
    output logic [WIDTH-1:0]    rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // No reset: contents survive an ownership reset, as block RAM does.
    always_ff @(posedge clk_in) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/frame_buffer_ctrl.sv
// N-bank frame store between the ray marcher and the display with mailbox
// ownership rotation; swaps are taken only at the display frame boundary.
`ifndef DISPLAY_WIDTH
`define DISPLAY_WIDTH 320
`endif
`ifndef DISPLAY_HEIGHT
`define DISPLAY_HEIGHT 180
`endif

module frame_buffer_ctrl
    import fb_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int DEPTH       = `DISPLAY_WIDTH * `DISPLAY_HEIGHT,
    parameter int ADDR_LEN    = $clog2(DEPTH),
    parameter int NUM_BUFFERS = 3,
    parameter int IDX_LEN     = $clog2(NUM_BUFFERS)
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                write_enable_in,
    input  logic [ADDR_LEN-1:0] write_addr_in,
    input  logic [WIDTH-1:0]    write_data_in,
    input  logic                write_frame_done_in,
    output logic                write_ready_out,
    input  logic [ADDR_LEN-1:0] read_addr_in,
    input  logic                read_frame_start_in,
    output logic [WIDTH-1:0]    read_data_out,
    output logic                read_valid_out,
    output logic [IDX_LEN-1:0]  write_buf_out,
    output logic [IDX_LEN-1:0]  read_buf_out,
    output logic [15:0]         dropped_frames_out
);

    localparam logic [ADDR_LEN:0] DEPTH_L = (ADDR_LEN + 1)'(DEPTH);

    own_t                                own_q, own_d;
    logic [DROP_W-1:0]                   drop_q, drop_d;
    logic                                drop_inc;
    logic                                done;
    swap_ev_e                            ev;
    buf_mask_t                           free_mask;
    logic                                wr_ok, rd_ok;
    logic [NUM_BUFFERS-1:0]              bank_we;
    logic [NUM_BUFFERS-1:0][WIDTH-1:0]   bank_q;
    logic [IDX_LEN-1:0]                  sel_q;
    logic [RD_LAT:1]                     vld_pipe;

    assign wr_ok = write_enable_in && own_q.write_ready && ({1'b0, write_addr_in} < DEPTH_L);
    assign rd_ok = {1'b0, read_addr_in} < DEPTH_L;
    assign done  = write_frame_done_in && own_q.write_ready;
    assign ev    = swap_ev_e'({read_frame_start_in, done});

    always_comb begin
        free_mask = '0;
        for (int i = 0; i < NUM_BUFFERS; i++) begin
            free_mask[i] = (buf_idx_t'(i) != own_q.read_idx)
                        && (buf_idx_t'(i) != own_q.write_idx)
                        && !(own_q.pending_valid && (buf_idx_t'(i) == own_q.pending_idx));
        end
    end

    // Ownership rotation. With two banks there is never a spare, so the
    // writer stalls instead of being handed a free bank.
    always_comb begin
        own_d    = own_q;
        drop_d   = drop_q;
        drop_inc = 1'b0;
        case (ev)
            EV_BOTH: begin
                own_d.read_idx      = own_q.write_idx;
                own_d.write_idx     = own_q.read_idx;
                own_d.pending_valid = 1'b0;
                drop_inc            = own_q.pending_valid;
            end
            EV_DONE: begin
                own_d.pending_idx = own_q.write_idx;
                if (own_q.pending_valid) begin
                    own_d.write_idx = own_q.pending_idx;
                    drop_inc        = 1'b1;
                end else begin
                    own_d.pending_valid = 1'b1;
                    if (NUM_BUFFERS == 2) own_d.write_ready = 1'b0;
                    else                  own_d.write_idx   = lowest_free(free_mask);
                end
            end
            EV_START: begin
                if (own_q.pending_valid) begin
                    own_d.read_idx      = own_q.pending_idx;
                    own_d.pending_valid = 1'b0;
                    if (NUM_BUFFERS == 2) begin
                        own_d.write_idx   = own_q.read_idx;
                        own_d.write_ready = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        if (drop_inc && (drop_q != '1)) drop_d = drop_q + 1'b1;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            own_q  <= OWN_RST;
            drop_q <= '0;
        end else begin
            own_q  <= own_d;
            drop_q <= drop_d;
        end
    end

    for (genvar g = 0; g < NUM_BUFFERS; g++) begin : g_bank
        assign bank_we[g] = wr_ok && (own_q.write_idx == buf_idx_t'(g));
        fb_bank #(
            .WIDTH    (WIDTH),
            .DEPTH    (DEPTH),
            .ADDR_LEN (ADDR_LEN)
        ) u_bank (
            .clk_in (clk_in),
            .we     (bank_we[g]),
            .waddr  (write_addr_in),
            .wdata  (write_data_in),
            .re     (rd_ok),
            .raddr  (read_addr_in),
            .rdata  (bank_q[g])
        );
    end

    // Bank index is captured with the address so a swap never splits a read.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            vld_pipe      <= '0;
            sel_q         <= '0;
            read_data_out <= '0;
        end else begin
            vld_pipe      <= {vld_pipe[RD_LAT-1:1], rd_ok};
            sel_q         <= own_q.read_idx[IDX_LEN-1:0];
            read_data_out <= bank_q[sel_q];
        end
    end

    assign read_valid_out     = vld_pipe[RD_LAT];
    assign write_ready_out    = own_q.write_ready;
    assign write_buf_out      = own_q.write_idx[IDX_LEN-1:0];
    assign read_buf_out       = own_q.read_idx[IDX_LEN-1:0];
    assign dropped_frames_out = drop_q;

`ifndef SYNTHESIS
    a_own_distinct: assert property (@(posedge clk_in) disable iff (rst_in)
        (own_q.read_idx != own_q.write_idx)
        && (!own_q.pending_valid || (own_q.pending_idx != own_q.read_idx))
        && (!(own_q.pending_valid && own_q.write_ready) || (own_q.pending_idx != own_q.write_idx)));
`endif

endmodule
